// File: rtl/mem_pkg.sv
// Shared encodings and default geometry for the unified-memory port arbiter.
// Latency: none (types, constants and a width helper only).
// Backpressure: none; flow control lives in the arbiter that imports this.
package mem_pkg;

    localparam int unsigned      AW_DEF         = 64;
    localparam int unsigned      DW_DEF         = 64;
    localparam longint unsigned  MEM_LIMIT_DEF  = 258;
    localparam int unsigned      LAT_DEF        = 2;
    localparam int unsigned      STARVE_MAX_DEF = 3;

    // Latency counter is sized for the largest legal LAT (7).
    localparam int unsigned      LAT_CW         = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } own_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_prio_sel.sv
// Grant selector: data side wins ties unless fetch has lost STARVE_MAX times.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is actually taken.
module mem_prio_sel
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned SW         = cnt_width(STARVE_MAX)
) (
    input  logic          d_req,
    input  logic          i_req,
    input  logic [SW-1:0] starve_cnt,
    output own_t          grant_own,
    output logic          grant_valid
);

    logic starved;

    always_comb begin
        starved     = (starve_cnt == SW'(STARVE_MAX));
        grant_valid = d_req | i_req;
        grant_own   = OWN_D;
        if (i_req && (!d_req || starved)) begin
            grant_own = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (read) and data (read/write).
// Latency: ack LAT+2 cycles after the grant decision, 1 cycle for address errors.
// Backpressure: requesters hold req until a one-cycle ack; one access in flight.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned     AW         = AW_DEF,
    parameter int unsigned     DW         = DW_DEF,
    parameter longint unsigned MEM_LIMIT  = MEM_LIMIT_DEF,
    parameter int unsigned     LAT        = LAT_DEF,
    parameter int unsigned     STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          d_req,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned       SW       = cnt_width(STARVE_MAX);
    localparam logic [AW-1:0]     LIMIT    = AW'(MEM_LIMIT);
    localparam logic [LAT_CW-1:0] LAT_LOAD = (LAT > 1) ? LAT_CW'(LAT - 1) : LAT_CW'(0);

    arb_state_t         state;
    own_t               owner;
    logic [LAT_CW-1:0]  lat_cnt;
    logic [SW-1:0]      starve_cnt;

    own_t               grant_own;
    logic               grant_valid;
    logic [AW-1:0]      sel_addr;
    logic               sel_we;
    logic               sel_err;
    logic               arb_go;

    mem_prio_sel #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_prio_sel (
        .d_req       (d_req),
        .i_req       (i_req),
        .starve_cnt  (starve_cnt),
        .grant_own   (grant_own),
        .grant_valid (grant_valid)
    );

    // Address/control of whichever side the selector picked this cycle.
    always_comb begin
        sel_addr = (grant_own == OWN_I) ? i_addr : d_addr;
        sel_we   = (grant_own == OWN_D) && d_write;
        sel_err  = (sel_addr >= LIMIT);
        arb_go   = (state == IDLE) && grant_valid && !d_ack && !i_ack;
    end

    // Counts consecutive lost arbitrations of a continuously waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!i_req) begin
            starve_cnt <= '0;
        end else if (arb_go) begin
            if (grant_own == OWN_I) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_D;
            lat_cnt   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            d_ack  <= 1'b0;
            i_ack  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (arb_go) begin
                        owner <= grant_own;
                        if (sel_err) begin
                            // Rejected in place: no memory strobe, writes dropped.
                            state <= ERR;
                            if (grant_own == OWN_I) begin
                                i_ack   <= 1'b1;
                                i_err   <= 1'b1;
                                i_rdata <= '0;
                            end else begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end
                        end else begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= d_wdata;
                        end
                    end
                end

                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        if (owner == OWN_I) begin
                            i_ack   <= 1'b1;
                            i_err   <= 1'b0;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CW'(1);
                    end
                end

                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference.
// Memory behind the port is modelled as an array with a LAT-deep read pipe.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int unsigned     AW         = 64;
    localparam int unsigned     DW         = 64;
    localparam longint unsigned MEM_LIMIT  = 258;
    localparam int unsigned     LAT        = 2;
    localparam int unsigned     STARVE_MAX = 3;
    localparam int              PHYS       = 512;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          d_req, d_write, d_ack, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          i_req, i_ack, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LIMIT(MEM_LIMIT), .LAT(LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] init_val(input int i);
        if (i == 5) return 64'h1122334455667788;
        return {32'(i) * 32'h9E3779B1, 32'hA5A50000 | 32'(i)};
    endfunction

    // Memory array behind the port; junk on the read pipe when not strobed.
    logic [DW-1:0] phys    [PHYS];
    logic [DW-1:0] rd_pipe [LAT];
    logic          mem_init = 1'b1;
    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < PHYS; a++) phys[a] <= init_val(a);
        end else if (mem_en && mem_we) begin
            phys[mem_addr[8:0]] <= mem_wdata;
        end
        rd_pipe[0] <= mem_en ? phys[mem_addr[8:0]] : {$urandom, $urandom};
        for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    // Reference state
    logic [63:0] ref_mem [PHYS];
    op_t         d_q[$], i_q[$];
    op_t         d_cur, i_cur;
    logic        d_cur_v, i_cur_v;
    logic        pend_v, pend_err, pend_we;
    own_t        pend_own;
    logic [63:0] pend_addr, pend_wdata, pend_rdata;
    int          pend_en, pend_ack;
    int          cyc, next_arb, losses, gap_pct;
    logic        rst_arm;
    logic        d_last_err, i_last_err, d_rd_dc;
    logic [63:0] d_last_rd, i_last_rd;
    own_t        ack_log[$];
    int          n_cmp, n_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_d_err"}, d_err, 0);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_i_err"}, i_err, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic check_outputs();
        logic e_en, e_da, e_ia;
        e_en = pend_v && !pend_err && (cyc == pend_en);
        e_da = pend_v && (cyc == pend_ack) && (pend_own == OWN_D);
        e_ia = pend_v && (cyc == pend_ack) && (pend_own == OWN_I);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_addr", mem_addr, pend_addr);
            chk("mem_we", mem_we, pend_we);
            if (pend_we) chk("mem_wdata", mem_wdata, pend_wdata);
        end
        chk("d_ack", d_ack, e_da);
        chk("i_ack", i_ack, e_ia);
        if (e_da) begin
            d_last_err = pend_err;
            d_last_rd  = pend_rdata;
            d_rd_dc    = pend_we && !pend_err;
        end
        if (e_ia) begin
            i_last_err = pend_err;
            i_last_rd  = pend_rdata;
        end
        chk("d_err", d_err, d_last_err);
        if (!d_rd_dc) chk("d_rdata", d_rdata, d_last_rd);
        chk("i_err", i_err, i_last_err);
        chk("i_rdata", i_rdata, i_last_rd);
        if (d_ack) ack_log.push_back(OWN_D);
        if (i_ack) ack_log.push_back(OWN_I);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        #1 rst_n = 1'b1;
        pend_v     = 1'b0;
        losses     = 0;
        next_arb   = cyc;
        d_last_err = 1'b0; d_last_rd = '0; d_rd_dc = 1'b0;
        i_last_err = 1'b0; i_last_rd = '0;
    endtask

    task automatic drive();
        if (!d_cur_v && d_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            d_cur = d_q.pop_front(); d_cur_v = 1'b1;
        end
        if (!i_cur_v && i_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            i_cur = i_q.pop_front(); i_cur_v = 1'b1;
        end
        d_req   = d_cur_v;
        d_write = d_cur.we;
        d_addr  = d_cur_v ? d_cur.addr : {$urandom, $urandom};
        d_wdata = d_cur.wdata;
        i_req   = i_cur_v;
        i_addr  = i_cur_v ? i_cur.addr : {$urandom, $urandom};
    endtask

    // One access at a time; ties go to data unless fetch has lost STARVE_MAX in a row.
    task automatic decide();
        own_t g;
        op_t  op;
        if (!pend_v && cyc >= next_arb && (d_cur_v || i_cur_v)) begin
            if (d_cur_v && i_cur_v) g = (losses == int'(STARVE_MAX)) ? OWN_I : OWN_D;
            else                    g = i_cur_v ? OWN_I : OWN_D;
            if (g == OWN_I) losses = 0;
            else if (i_cur_v && losses < int'(STARVE_MAX)) losses++;
            op         = (g == OWN_I) ? i_cur : d_cur;
            pend_v     = 1'b1;
            pend_own   = g;
            pend_addr  = op.addr;
            pend_we    = op.we;
            pend_wdata = op.wdata;
            pend_err   = (op.addr >= MEM_LIMIT);
            pend_en    = cyc + 1;
            pend_ack   = pend_err ? cyc + 1 : cyc + int'(LAT) + 2;
            pend_rdata = pend_err ? 64'd0 : ref_mem[op.addr[8:0]];
            if (op.we && !pend_err) ref_mem[op.addr[8:0]] = op.wdata;
            next_arb   = pend_ack + 1;
        end
        if (!i_cur_v) losses = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (pend_v && cyc == pend_ack) begin
            if (pend_own == OWN_D) d_cur_v = 1'b0;
            else                   i_cur_v = 1'b0;
            pend_v = 1'b0;
        end
        if (rst_arm && pend_v && pend_own == OWN_I && cyc == pend_en + 1) begin
            reset_pulse();
            rst_arm = 1'b0;
        end
        drive();
        decide();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((d_q.size() > 0 || i_q.size() > 0 || d_cur_v || i_cur_v || pend_v) && n < budget) begin
            step();
            n++;
        end
        chk("drain", (d_q.size() == 0 && i_q.size() == 0 && !d_cur_v && !i_cur_v && !pend_v), 1);
        repeat (2) step();
    endtask

    function automatic op_t rand_op(input bit allow_w);
        op_t o;
        int  r;
        r      = int'($urandom_range(0, 99));
        o.we   = allow_w && ($urandom_range(0, 2) == 0);
        o.wdata = {$urandom, $urandom};
        if (r < 55)      o.addr = 64'($urandom_range(0, 15));
        else if (r < 70) o.addr = 64'($urandom_range(0, 32'(MEM_LIMIT - 1)));
        else if (r < 82) o.addr = 64'($urandom_range(255, 260));
        else if (r < 92) o.addr = 64'($urandom_range(0, 600));
        else             o.addr = {$urandom, $urandom};
        return o;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        own_t pat [8];
        pat = '{OWN_D, OWN_D, OWN_D, OWN_I, OWN_D, OWN_D, OWN_D, OWN_I};
        n_cmp = 0; n_bad = 0; cyc = 0; next_arb = 0; losses = 0; gap_pct = 0;
        rst_arm = 1'b0; pend_v = 1'b0; d_cur_v = 1'b0; i_cur_v = 1'b0;
        d_cur = '0; i_cur = '0; pend_own = OWN_D; pend_en = -1; pend_ack = -1;
        d_last_err = 1'b0; d_last_rd = '0; d_rd_dc = 1'b0;
        i_last_err = 1'b0; i_last_rd = '0;
        for (int a = 0; a < PHYS; a++) ref_mem[a] = init_val(a);
        rst_n = 1'b0; d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk_all_zero("reset");
        rst_n = 1'b1;

        d_q.push_back('{1'b0, 64'd5, 64'd0});
        run(50);
        chk("rd5_data", d_rdata, 64'h1122334455667788);
        chk("rd5_err", d_err, 0);

        d_q.push_back('{1'b1, 64'd10, 64'hDEAD});
        run(50);
        i_q.push_back('{1'b0, 64'd10, 64'd0});
        run(50);
        chk("fetch10_data", i_rdata, 64'hDEAD);

        d_q.push_back('{1'b0, 64'd258, 64'd0});
        run(50);
        chk("err258_err", d_err, 1);
        chk("err258_rdata", d_rdata, 0);
        d_q.push_back('{1'b0, 64'd257, 64'd0});
        run(50);
        chk("ok257_err", d_err, 0);

        ack_log.delete();
        for (int j = 0; j < 8; j++) d_q.push_back('{1'b0, 64'(40 + j), 64'd0});
        i_q.push_back('{1'b0, 64'd30, 64'd0});
        i_q.push_back('{1'b0, 64'd31, 64'd0});
        run(200);
        chk("order_len", (ack_log.size() >= 8), 1);
        for (int j = 0; j < 8; j++) begin
            if (j < ack_log.size()) chk("grant_order", ack_log[j], pat[j]);
        end

        d_q.push_back('{1'b1, 64'd300, 64'hDEAD_BEEF_0BAD_F00D});
        d_q.push_back('{1'b0, 64'd300, 64'd0});
        run(50);
        chk("wr300_untouched", phys[300], init_val(300));
        chk("rd300_err", d_err, 1);

        rst_arm = 1'b1;
        i_q.push_back('{1'b0, 64'd20, 64'd0});
        run(50);
        chk("fetch20_after_rst", i_rdata, init_val(20));

        gap_pct = 25;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) d_q.push_back(rand_op(1'b1));
            else                           i_q.push_back(rand_op(1'b0));
        end
        run(8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
